// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing, scan-out FIFO geometry and timing helpers.
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int FIFO_DEPTH = 8;
  localparam int PIX_PER_WORD = 4;
  function automatic int span(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port and video output bundle of the scan-out engine.
interface vga_scanout_if #(parameter int WIDTH = 32);
  logic pix_ce;
  logic [WIDTH-1:0] rd_address;
  logic rd_req;
  logic [WIDTH-1:0] rd_data;
  logic hsync;
  logic vsync;
  logic de;
  logic [7:0] pixel;
  logic frame_irq;
  logic underflow;
  modport master(input pix_ce, rd_data, output rd_address, rd_req, hsync, vsync, de, pixel, frame_irq, underflow);
  modport slave(output pix_ce, rd_data, input rd_address, rd_req, hsync, vsync, de, pixel, frame_irq, underflow);
endinterface

// File: rtl/scanout_fifo.sv
// scanout_fifo: first-word-fall-through word FIFO with flush and occupancy count.
module scanout_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_comb begin
    dout = mem[rp];
    empty = count == '0;
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that prefetches framebuffer words and unpacks them into pixels.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FB_BASE = 0,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP
) (
  input logic clk,
  input logic reset,
  vga_scanout_if.master bus
);
  localparam int H_TOTAL = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int N = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int WW = $clog2(N + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [HW-1:0] HA = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0 = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1 = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HL = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VAL = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VL = VW'(V_TOTAL - 1);
  localparam logic [WW-1:0] WN = WW'(N);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [WW-1:0] wcnt;
  logic [1:0] idx;
  logic pend;
  logic [CW-1:0] count;
  logic empty;
  logic [WIDTH-1:0] head;
  logic active, h_last, boundary, need, pop, issue;
  logic [7:0] cur;
  // Issue gating counts both the read on the bus and the word about to be pushed, so the FIFO can never overflow.
  always_comb begin
    active = h_cnt < HA && v_cnt < VA;
    h_last = h_cnt == HL;
    boundary = bus.pix_ce && h_last && v_cnt == VAL;
    need = bus.pix_ce && active;
    pop = need && !empty && idx == 2'd3;
    issue = !boundary && wcnt < WN && (count + CW'(bus.rd_req) + CW'(pend)) < CW'(FIFO_DEPTH);
    cur = head[{idx, 3'b000} +: 8];
  end
  scanout_fifo #(.DEPTH(FIFO_DEPTH), .W(WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(pend),
    .pop(pop),
    .flush(boundary),
    .din(bus.rd_data),
    .dout(head),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      wcnt <= '0;
      idx <= '0;
      pend <= 1'b0;
      bus.rd_req <= 1'b0;
      bus.rd_address <= WIDTH'(FB_BASE);
      bus.hsync <= 1'b1;
      bus.vsync <= 1'b1;
      bus.de <= 1'b0;
      bus.pixel <= '0;
      bus.frame_irq <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.frame_irq <= boundary;
      pend <= bus.rd_req && !boundary;
      bus.rd_req <= issue;
      if (boundary) begin
        wcnt <= '0;
        bus.rd_address <= WIDTH'(FB_BASE);
        idx <= '0;
        bus.underflow <= 1'b0;
      end else begin
        if (issue) begin
          wcnt <= wcnt + WW'(1);
          bus.rd_address <= WIDTH'(FB_BASE) + WIDTH'(wcnt);
        end
        if (need && !empty) idx <= idx + 2'd1;
        if (need && empty) bus.underflow <= 1'b1;
      end
      if (bus.pix_ce) begin
        h_cnt <= h_last ? '0 : h_cnt + HW'(1);
        if (h_last) v_cnt <= (v_cnt == VL) ? '0 : v_cnt + VW'(1);
        bus.de <= active;
        bus.hsync <= !(h_cnt >= HS0 && h_cnt < HS1);
        bus.vsync <= !(v_cnt >= VS0 && v_cnt < VS1);
        bus.pixel <= (active && !empty) ? cur : 8'd0;
      end
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display scan-out engine downstream of `videocard`. It reads the framebuffer that `videocard` renders into a dedicated read port of the shared `RAM`. It unpacks 32-bit words into 8-bit pixels and generates VGA-style sync, blanking and pixel outputs. Once per frame it emits `frame_irq`; the top level routes this pulse into `videocard.interrupt_start` so rendering of the next frame starts on vertical blank.

## Interface
- `WIDTH`, 32: RAM data/address width; fixed at 32, 4 pixels per word.
- `FB_BASE`, 0: word address of pixel (0,0).
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 4.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `clk`  in  1  system clock, same clock as `RAM`/`videocard`.
- `reset`  in  1  asynchronous, active-high reset.
- `pix_ce`  in  1  pixel clock enable; one pixel step per cycle where high.
- `rd_address`  out  WIDTH  framebuffer read address.
- `rd_req`  out  1  a read of `rd_address` is issued this cycle.
- `rd_data`  in  WIDTH  RAM `q`; valid exactly 1 cycle after `rd_req`.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `de`  out  1  display enable (active video).
- `pixel`  out  8  pixel value; 0 whenever `de`=0.
- `frame_irq`  out  1  one-`clk` pulse at start of vertical blank.
- `underflow`  out  1  sticky: FIFO was empty when an active pixel was needed.

## Operation
- Timing counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1), with H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. They advance only on `pix_ce`. `h_cnt` wraps to 0 and increments `v_cnt`; `v_cnt` wraps to 0 after V_TOTAL-1.
- Active region: `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
- `hsync`=0 for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). `vsync`=0 for the analogous range of `v_cnt`.
- Fetch engine:
  - Word counter `wcnt` runs 0..N-1, with N=H_ACTIVE*V_ACTIVE/4.
  - Issue `rd_req`=1 with `rd_address`=FB_BASE+`wcnt` when `wcnt`<N and FIFO occupancy plus in-flight reads < 8. At most one read per cycle; `wcnt` increments on issue.
  - The returned `rd_data` is pushed into the FIFO on the following cycle, unconditionally.
- Unpack: a 2-bit pixel index selects byte 0 (bits 7:0) first, then byte 1, 2, 3. The FIFO word is popped when byte 3 is consumed by an active `pix_ce`.
- Frame boundary: on the `pix_ce` where the counters enter (`h_cnt`=0, `v_cnt`=V_ACTIVE), all of the following happen:
  - `frame_irq` pulses.
  - `wcnt` resets to 0.
  - The FIFO flushes and the pixel index resets.
  - A read returning in the next cycle is dropped.
  - Prefetch for the next frame starts in the following cycle, during vblank.
- Underflow: an active pixel needed while the FIFO is empty outputs `pixel`=0, does not pop, and sets `underflow`. `underflow` clears at the frame boundary.

## Timing
- Outputs are registered. On each `pix_ce` edge, `hsync`/`vsync`/`de`/`pixel` take values decoded from the pre-increment counters, i.e. they lag the counters by one pixel step.
- `frame_irq` is high for exactly one `clk` cycle, the cycle after that `pix_ce` edge, regardless of `pix_ce` rate.
- RAM read latency is 1 cycle. Fetch bandwidth is one word per `clk`; with `pix_ce` ≤ 1/2 duty the FIFO never underflows after prefetch.
- Simultaneous push and pop in one cycle: occupancy unchanged. Push when full cannot occur, by the in-flight accounting.
- Reset values (asynchronous assert, sync deassert by top level):
  - `h_cnt`=`v_cnt`=0, `wcnt`=0, FIFO empty, in-flight cleared.
  - `rd_address`=FB_BASE, `rd_req`=0.
  - `hsync`=`vsync`=1, `de`=0, `pixel`=0, `frame_irq`=0, `underflow`=0.
- Reset mid-frame: a pending read is discarded and the scan restarts at (0,0). The first frame after reset has no prefetch lead and may underflow on its first pixels; `underflow` records it.

## Structure
- Package `vga_timing_pkg`: default timing constants, derived H_TOTAL/V_TOTAL, FIFO depth (8), pixels-per-word (4).
- Sub-module `scanout_fifo`: 8×32 synchronous FIFO with push, pop, flush, `empty` and `count` outputs. Counters, fetch and unpack live in `vga_scanout`.

## Test plan
The first four scenarios use small timing: H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, `pix_ce` every 2nd cycle. The RAM is preloaded so that word k = {4k+3, 4k+2, 4k+1, 4k} (bytes).
- Pixel order: frame 2 line 0 -> `pixel` sequence 0,1,…,7 with `de`=1. Line 3 -> 24..31.
- Sync widths: `hsync` is low for exactly 2 pixel steps per 14-step line. `vsync` is low for exactly 1 line (14 steps) per 7-line frame.
- `frame_irq`: exactly one 1-cycle pulse per frame, 98 pixel steps apart. `wcnt` and `rd_address` return to FB_BASE the cycle after.
- Fetch limit: `rd_req` asserts exactly 8 times per frame. It is never asserted with occupancy plus in-flight = 8.
- Underflow: set `pix_ce`=1 every cycle and stall reads via reset of the prefetch (reset released 1 cycle before active video) -> `underflow`=1 and `pixel`=0 for missing pixels. `underflow` clears at the next `frame_irq`.
- Async reset asserted mid-line -> all outputs at reset values within the same cycle. Output restarts with pixel 0 at (0,0).
